// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one byte read at a time to instruction
// memory, buffers returned bytes in a small prefetch FIFO and hands them to
// decode in order, with backpressure and branch-redirect flushing.
module fetch_unit #(
   parameter logic [7:0] RESET_PC = 8'h00,
   parameter int         DEPTH    = 4
) (
   input  logic       clk,
   input  logic       sync_rst,
   output logic       imem_req,
   output logic [7:0] imem_addr,
   input  logic       imem_ack,
   input  logic [7:0] imem_data,
   output logic [7:0] opcode,
   output logic       opcode_valid,
   output logic [7:0] opcode_pc,
   input  logic       hold,
   input  logic       redirect,
   input  logic [7:0] redirect_pc
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   state_t         state, state_nx;
   logic [7:0]     fetch_pc, fetch_pc_nx;   // next address to be requested
   logic [7:0]     req_addr, req_addr_nx;   // address of the outstanding request
   logic           discard, discard_nx;     // outstanding response must be dropped
   logic [15:0]    mem [DEPTH];             // {data, pc} per entry
   logic [AW-1:0]  rd_ptr, wr_ptr;
   logic [CW-1:0]  count, count_nx;
   logic [7:0]     last_op, last_pc;
   logic [15:0]    head;
   logic [7:0]     base_pc;
   logic           push, pop, issue;

   // Next-state, FIFO control and request-issue decisions.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
      state_nx    = state;
      issue       = 1'b0;
      head        = mem[rd_ptr];
      push        = (state == S_WAIT) && imem_ack && !discard && !redirect;
      pop         = (count != '0) && !hold && !redirect;
      base_pc     = redirect ? redirect_pc : fetch_pc;
      count_nx    = redirect ? '0 : count + CW'(push) - CW'(pop);

      // A new request is allowed only if the entries left after this edge
      // plus the new pending byte still fit, so a push can never overflow.
      case (state)
         S_IDLE: issue = (count_nx < CW'(DEPTH));
         S_WAIT: issue = imem_ack && (count_nx < CW'(DEPTH));
         default: issue = 1'b0;
      endcase

      if (issue)
         state_nx = S_WAIT;
      else if ((state == S_WAIT) && imem_ack)
         state_nx = S_IDLE;

      fetch_pc_nx = issue ? base_pc + 8'd1 : base_pc;
      req_addr_nx = issue ? base_pc : req_addr;

      // A redirect while a request is still in flight keeps the address
      // stable and marks the eventual response for dropping.
      discard_nx  = (state == S_WAIT) && !imem_ack && (redirect || discard);
   end

   // Control state, pointers and last-shown output registers.
   always_ff @(posedge clk) begin
      if (sync_rst) begin
         state    <= S_IDLE;
         fetch_pc <= RESET_PC;
         req_addr <= RESET_PC;
         discard  <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         last_op  <= 8'h00;
         last_pc  <= 8'h00;
      end else begin
         state    <= state_nx;
         fetch_pc <= fetch_pc_nx;
         req_addr <= req_addr_nx;
         discard  <= discard_nx;
         count    <= count_nx;
         if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
         end
         if (count != '0) begin
            last_op <= head[15:8];
            last_pc <= head[7:0];
         end
      end
   end

   // Prefetch storage write port.
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; count gates visibility, so stale entries are never shown.
      if (push && !sync_rst)
         mem[wr_ptr] <= {imem_data, imem_addr};
   end

   assign imem_req     = (state == S_WAIT);
   assign imem_addr    = req_addr;
   assign opcode_valid = (count != '0);
   assign opcode       = opcode_valid ? head[15:8] : last_op;
   assign opcode_pc    = opcode_valid ? head[7:0]  : last_pc;

endmodule
